// File: rtl/mem_access_if.sv
// mem_access_if: pipeline request and data-memory handshake bundle for mem_access
interface mem_access_if;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        byte_in;
    logic        indirect_in;
    logic [15:0] address_in;
    logic [15:0] store_data_in;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] load_data;
    logic        mem_stall;

    modport slave (
        input  valid_in, mem_read_in, mem_write_in, byte_in, indirect_in,
        input  address_in, store_data_in, dmem_rdata, dmem_resp,
        output dmem_address, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_wdata, load_data, mem_stall
    );

    modport master (
        output valid_in, mem_read_in, mem_write_in, byte_in, indirect_in,
        output address_in, store_data_in, dmem_rdata, dmem_resp,
        input  dmem_address, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_wdata, load_data, mem_stall
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: LC-3b memory-stage controller with indirect pointer fetch and byte lanes
module mem_access (
    input logic         clk,
    input logic         rst_n,
    mem_access_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IND_READ, DATA_READ, DATA_WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] ptr_reg;
    logic [15:0] load_q;
    logic [15:0] eff;
    logic [7:0]  rbyte;
    logic        active;

    assign active = bus.valid_in & (bus.mem_read_in | bus.mem_write_in);
    assign eff    = bus.indirect_in ? ptr_reg : bus.address_in;
    assign rbyte  = eff[0] ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0];

    // Requests come from state alone so a reset drops them without waiting for resp
    assign bus.dmem_read        = (state == IND_READ) | (state == DATA_READ);
    assign bus.dmem_write       = state == DATA_WRITE;
    assign bus.dmem_address     = (state == IND_READ) ? bus.address_in :
                                  (bus.dmem_read | bus.dmem_write) ? eff : 16'h0;
    assign bus.dmem_byte_enable = !bus.dmem_write ? 2'b00 : !bus.byte_in ? 2'b11 :
                                  eff[0] ? 2'b10 : 2'b01;
    assign bus.dmem_wdata       = !bus.dmem_write ? 16'h0 :
                                  bus.byte_in ? {2{bus.store_data_in[7:0]}} : bus.store_data_in;
    assign bus.mem_stall        = bus.dmem_read | bus.dmem_write | ((state == IDLE) & active);
    assign bus.load_data        = load_q;

    // Access sequencer; once started, an access always runs until its final resp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr_reg <= 16'h0;
            load_q  <= 16'h0;
        end else begin
            case (state)
                IDLE:       if (active) state <= bus.indirect_in ? IND_READ :
                                                 bus.mem_write_in ? DATA_WRITE : DATA_READ;
                IND_READ:   if (bus.dmem_resp) begin
                                ptr_reg <= bus.dmem_rdata;
                                state   <= bus.mem_write_in ? DATA_WRITE : DATA_READ;
                            end
                DATA_READ:  if (bus.dmem_resp) begin
                                load_q <= bus.byte_in ? {{8{rbyte[7]}}, rbyte} : bus.dmem_rdata;
                                state  <= DONE;
                            end
                DATA_WRITE: if (bus.dmem_resp) state <= DONE;
                default:    state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access controller for the LC-3b pipeline. It consumes the memory request presented by the execute/memory pipeline register: the effective address, store data, access kind and the valid bit. It drives the single-port data-memory handshake, including two-access indirect loads/stores (LDI/STI) and byte lanes (LDB/STB). It returns the loaded word and holds `mem_stall` high until the access completes, freezing the upstream stages.

## Interface
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  pipeline-register instruction is valid
- `mem_read_in`  in  1  instruction loads from memory (LDR/LDB/LDI)
- `mem_write_in`  in  1  instruction stores to memory (STR/STB/STI)
- `byte_in`  in  1  byte-sized final access (LDB/STB)
- `indirect_in`  in  1  pointer fetch precedes final access (LDI/STI)
- `address_in`  in  16  effective address from execute
- `store_data_in`  in  16  store source register value
- `dmem_address`  out  16  data-memory address
- `dmem_read`  out  1  read request
- `dmem_write`  out  1  write request
- `dmem_byte_enable`  out  2  write lane enables; [1] = high byte
- `dmem_wdata`  out  16  write data
- `dmem_rdata`  in  16  read data; valid when `dmem_resp` is 1
- `dmem_resp`  in  1  one-cycle completion of the current read or write
- `load_data`  out  16  registered result of the last completed load
- `mem_stall`  out  1  hold the pipeline; upstream inputs are stable while this is 1

## Operation
- **Access condition.** A request is active when `valid_in & (mem_read_in | mem_write_in)`. If both read and write are set, the access is a write.
- **States:** IDLE, IND_READ, DATA_READ, DATA_WRITE, DONE.
- **IDLE**
  - Active request with `indirect_in` → IND_READ.
  - Otherwise write → DATA_WRITE; read → DATA_READ.
  - No active request → stay in IDLE.
- **IND_READ**
  - Drives `dmem_read`=1 and `dmem_address=address_in`; the read is always word-sized.
  - On `dmem_resp`, latch `ptr_reg <= dmem_rdata`, then go to DATA_WRITE if the access is a write, else DATA_READ.
- **DATA_READ / DATA_WRITE address.** `dmem_address = indirect_in ? ptr_reg : address_in` (called `eff` below).
- **DATA_READ**
  - Drives `dmem_read`=1. On `dmem_resp`, update `load_data` and go to DONE.
  - Word load: `load_data = dmem_rdata`.
  - Byte load: take byte `eff[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]`, sign-extended to 16 bits.
- **DATA_WRITE**
  - Drives `dmem_write`=1. On `dmem_resp`, go to DONE.
  - Word store: `dmem_byte_enable=2'b11`, `dmem_wdata=store_data_in`.
  - Byte store: `dmem_byte_enable = eff[0] ? 2'b10 : 2'b01`, `dmem_wdata = {store_data_in[7:0], store_data_in[7:0]}`.
- **DONE:** `mem_stall`=0 for exactly one cycle so the pipeline advances, then unconditionally return to IDLE.
- **Stall equation:** `mem_stall = (state∈{IND_READ,DATA_READ,DATA_WRITE}) | (state==IDLE & active request)`. The output is combinational.
- **Request outputs.** `dmem_read`/`dmem_write` are combinational from state only and are never both 1. They are 0 in IDLE and DONE.
- **Non-access instructions.** Invalid instructions and instructions that are neither load nor store pass through IDLE with `mem_stall`=0 and zero latency.
- **No abort.** Once the FSM leaves IDLE, the access runs to completion even if `valid_in` drops; memory transactions are never aborted.
- **Word alignment.** Word accesses present the full `eff`; memory ignores bit 0. No alignment exception.
- **Read-side outputs outside writes.** `dmem_wdata` and `dmem_byte_enable` are don't-care except in DATA_WRITE. Drive them 0 outside DATA_WRITE.

## Timing
- **Reset (asynchronous, `rst_n`=0):**
  - state = IDLE; `ptr_reg` = 0; `load_data` = 0.
  - `dmem_read`, `dmem_write`, `dmem_byte_enable`, `dmem_wdata`, `dmem_address` = 0.
  - `mem_stall` follows its equation (0 unless a request is presented).
  - Reset asserted mid-access drops `dmem_read`/`dmem_write` immediately, with no resp wait.
- **Direct access with zero-wait memory** (resp in the first request cycle):
  - cycle 0: IDLE, stall=1.
  - cycle 1: request, resp.
  - cycle 2: DONE, stall=0.
  - Total 3 cycles, 2 stall cycles.
- **Indirect access, zero-wait:** 4 cycles, 3 stall cycles.
- **Waits:** each memory wait cycle adds one stall cycle; requests and address stay stable until `dmem_resp`.
- **`load_data`:** valid from the DONE cycle onward; held until the next completed DATA_READ. Stores and IND_READ never change it.
- **Ignored responses:** `dmem_resp` in IDLE or DONE is ignored.

## Test plan
- **Word load:** LDR with `address_in`=0x3000, rdata=0xBEEF, resp after 2 wait cycles → `dmem_read` high 3 cycles at 0x3000, stall high 4 cycles, then `load_data`=0xBEEF with stall=0 for one cycle.
- **Byte load, high lane:** LDB with addr=0x3001, rdata=0x80FF → `load_data`=0xFF80. With addr=0x3000 → 0xFFFF.
- **Byte store:** STB with addr=0x4001, store_data=0x1234 → `dmem_write`=1, `byte_enable`=2'b10, `wdata`=0x3434, `dmem_read` never asserted.
- **Indirect store:** STI with addr=0x5000, pointer read returns 0x6002, store_data=0xA5A5 →
  - read at 0x5000;
  - then write at 0x6002 with `byte_enable`=2'b11, `wdata`=0xA5A5;
  - 3 stall cycles with zero-wait memory.
- **Pass-through and stray resp:** ADD with valid=1, no mem bits → stall=0 and no requests. `dmem_resp` pulsed in IDLE → no state change.
- **Reset mid-access:** `rst_n`=0 during LDI IND_READ → `dmem_read` drops in the same cycle and `ptr_reg`=`load_data`=0. After release, a new LDR completes normally.
